// File: rtl/window_if.sv
// Column-in / window-out stream bundle for the window builder.
// The slave side is the window block; the master side feeds columns and
// consumes windows.
interface window_if #(
  parameter int unsigned HEIGHT_NB = 3,
  parameter int unsigned WIDTH_NB  = 3,
  parameter int unsigned IMG_WIDTH = 8
);
  logic [IMG_WIDTH*HEIGHT_NB-1:0]          up_data;
  logic                                    up_val;
  logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] dn_data;
  logic                                    dn_val;
  logic                                    dn_eol;
  logic                                    dn_last;

  modport master (
    output up_data, up_val,
    input  dn_data, dn_val, dn_eol, dn_last
  );

  modport slave (
    input  up_data, up_val,
    output dn_data, dn_val, dn_eol, dn_last
  );
endinterface

// File: rtl/window.sv
// Sliding-window builder: shifts incoming pixel columns into a WIDTH_NB-deep
// array and flags complete windows, end-of-row and end-of-frame.
module window #(
  parameter int unsigned HEIGHT_NB = 3,
  parameter int unsigned WIDTH_NB  = 3,
  parameter int unsigned IMG_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_rows,
  input  logic                 cfg_set,
  window_if.slave              bus
);

  localparam int unsigned COL_BITS = IMG_WIDTH * HEIGHT_NB;
  localparam int unsigned WIN_BITS = COL_BITS * WIDTH_NB;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cfg_width_q, cfg_width_d;
  logic [CNT_WIDTH-1:0] cfg_rows_q, cfg_rows_d;
  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic [WIN_BITS-1:0]  win_q, win_d;
  logic                 dn_val_q, dn_val_d;
  logic                 dn_eol_q, dn_eol_d;
  logic                 dn_last_q, dn_last_d;
  logic                 at_eol;
  logic                 at_last_row;

  // Next-state: config latch, column shift, counters and window flags
  always_comb begin
    state_d     = state_q;
    cfg_width_d = cfg_width_q;
    cfg_rows_d  = cfg_rows_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    dn_val_d    = 1'b0;
    dn_eol_d    = 1'b0;
    dn_last_d   = 1'b0;
    at_eol      = (col_q == cfg_width_q - CNT_WIDTH'(1));
    at_last_row = (row_q == cfg_rows_q - CNT_WIDTH'(1));

    if (cfg_set) begin
      // cfg_set wins over a coincident column beat, which is dropped
      cfg_width_d = cfg_width;
      cfg_rows_d  = cfg_rows;
      col_d       = '0;
      row_d       = '0;
      state_d     = (cfg_width >= CNT_WIDTH'(WIDTH_NB) && cfg_rows != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.up_val) begin
      win_d = win_q >> COL_BITS;
      win_d[WIN_BITS-1 -: COL_BITS] = bus.up_data;
      dn_val_d  = (col_q >= CNT_WIDTH'(WIDTH_NB - 1));
      dn_eol_d  = at_eol;
      dn_last_d = at_eol && at_last_row;
      if (at_eol) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + CNT_WIDTH'(1);
      end else begin
        col_d = col_q + CNT_WIDTH'(1);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_width_q <= '0;
      cfg_rows_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      dn_val_q    <= 1'b0;
      dn_eol_q    <= 1'b0;
      dn_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_width_q <= cfg_width_d;
      cfg_rows_q  <= cfg_rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      dn_val_q    <= dn_val_d;
      dn_eol_q    <= dn_eol_d;
      dn_last_q   <= dn_last_d;
    end
  end

  assign bus.dn_data = win_q;
  assign bus.dn_val  = dn_val_q;
  assign bus.dn_eol  = dn_eol_q;
  assign bus.dn_last = dn_last_q;

endmodule

// File: tb/tb_window.sv
// Directed bench for the window builder: frame timing, window contents,
// gapped input, back-to-back frames, config handling and mid-frame reset.
module tb_window;

  localparam int unsigned H   = 3;
  localparam int unsigned W   = 3;
  localparam int unsigned IW  = 8;
  localparam int unsigned CW  = 12;
  localparam int unsigned WB  = IW * H * W;
  localparam int unsigned CB  = IW * H;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_width;
  logic [CW-1:0] cfg_rows;
  logic          cfg_set;

  window_if #(.HEIGHT_NB(H), .WIDTH_NB(W), .IMG_WIDTH(IW)) bus ();

  window #(
    .HEIGHT_NB(H),
    .WIDTH_NB (W),
    .IMG_WIDTH(IW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_width(cfg_width),
    .cfg_rows (cfg_rows),
    .cfg_set  (cfg_set),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_dnval  = 0;
  int cur_w    = 0;
  int cur_rows = 0;
  logic [WB-1:0] m_win = '0;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Column k: row h pixel = k + 64*h, so row slicing errors are visible
  function automatic logic [CB-1:0] col_word(input int k);
    logic [7:0] p0, p1, p2;
    p0 = 8'(k);
    p1 = 8'(k + 64);
    p2 = 8'(k + 128);
    return {p2, p1, p0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One column beat; run selects whether the block is expected to be running
  task automatic beat(input int k, input bit run);
    int c, r;
    logic ev, ee, el;
    bus.up_data = col_word(k);
    bus.up_val  = 1'b1;
    tick();
    bus.up_val  = 1'b0;
    ev = 1'b0; ee = 1'b0; el = 1'b0;
    if (run) begin
      c  = k % cur_w;
      r  = (k / cur_w) % cur_rows;
      ev = (c >= int'(W) - 1);
      ee = (c == cur_w - 1);
      el = ee && (r == cur_rows - 1);
      m_win = {col_word(k), m_win[WB-1:CB]};
    end
    if (bus.dn_val === 1'b1) n_dnval++;
    check($sformatf("val k=%0d", k), WB'(bus.dn_val), WB'(ev));
    check($sformatf("eol k=%0d", k), WB'(bus.dn_eol), WB'(ee));
    check($sformatf("last k=%0d", k), WB'(bus.dn_last), WB'(el));
    check($sformatf("data k=%0d", k), bus.dn_data, m_win);
  endtask

  task automatic idle();
    bus.up_val = 1'b0;
    tick();
    check("gap val", WB'(bus.dn_val), '0);
    check("gap eol", WB'(bus.dn_eol), '0);
    check("gap last", WB'(bus.dn_last), '0);
    check("gap data", bus.dn_data, m_win);
  endtask

  task automatic cfg(input int wv, input int rv, input bit with_val);
    cfg_width   = CW'(wv);
    cfg_rows    = CW'(rv);
    cfg_set     = 1'b1;
    bus.up_val  = with_val;
    bus.up_data = '1;
    tick();
    cfg_set    = 1'b0;
    bus.up_val = 1'b0;
    cur_w      = wv;
    cur_rows   = rv;
    check("cfg val", WB'(bus.dn_val), '0);
    check("cfg eol", WB'(bus.dn_eol), '0);
    check("cfg last", WB'(bus.dn_last), '0);
    check("cfg data", bus.dn_data, m_win);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_win = '0;
    check("rst val", WB'(bus.dn_val), '0);
    check("rst eol", WB'(bus.dn_eol), '0);
    check("rst last", WB'(bus.dn_last), '0);
    check("rst data", bus.dn_data, '0);
  endtask

  initial begin
    rst = 1'b1; cfg_set = 1'b0; cfg_width = '0; cfg_rows = '0;
    bus.up_val = 1'b0; bus.up_data = '0;
    tick();
    do_reset();

    // Beats before any configuration are ignored
    for (int k = 0; k < 4; k++) beat(k, 1'b0);

    // Width below window width keeps the block idle
    cfg(2, 4, 1'b0);
    for (int k = 0; k < 4; k++) beat(k, 1'b0);

    // Basic frame then a second frame back-to-back; coincident beat dropped
    cfg(8, 4, 1'b1);
    n_dnval = 0;
    for (int k = 0; k < 32; k++) beat(k, 1'b1);
    check("pulses frame1", WB'(n_dnval), WB'(24));
    for (int k = 32; k < 64; k++) beat(k, 1'b1);
    check("pulses frame2", WB'(n_dnval), WB'(48));

    // Gapped input
    cfg(8, 4, 1'b0);
    n_dnval = 0;
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 1) == 1) idle();
      beat(k, 1'b1);
    end
    check("pulses gapped", WB'(n_dnval), WB'(24));

    // Restart mid-row at col=5
    cfg(8, 4, 1'b0);
    for (int k = 0; k < 5; k++) beat(k, 1'b1);
    cfg(8, 4, 1'b0);
    for (int k = 0; k < 3; k++) beat(k, 1'b1);

    // Zero rows is illegal and drops back to idle
    cfg(8, 0, 1'b0);
    for (int k = 0; k < 3; k++) beat(k, 1'b0);

    // Reset mid-frame after beat 10
    cfg(8, 4, 1'b0);
    for (int k = 0; k < 11; k++) beat(k, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) beat(k, 1'b0);
    cfg(8, 4, 1'b0);
    for (int k = 0; k < 8; k++) beat(k, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window.md
# window

Sliding-window builder sitting directly downstream of `delay`. It consumes the column bus that `delay` produces: HEIGHT_NB vertically aligned pixels per beat, qualified by `delay_val`. It shifts successive columns into a WIDTH_NB-deep register array and emits a complete HEIGHT_NB x WIDTH_NB window to the filter. Column and row counters suppress windows that straddle a row boundary, and they flag end-of-row and end-of-frame.

## Interface
- HEIGHT_NB, 3, window height (must match `delay`)
- WIDTH_NB, 3, window width, >= 1
- IMG_WIDTH, 8, bits per pixel
- CNT_WIDTH, 12, width of column/row counters and config fields
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_width  in  CNT_WIDTH  image width in pixels (columns per row)
- cfg_rows  in  CNT_WIDTH  column rows per frame delivered by `delay` (image height - HEIGHT_NB + 1)
- cfg_set  in  1  latch cfg_width/cfg_rows, restart frame
- up_data  in  IMG_WIDTH*HEIGHT_NB  column from `delay`; slice h=0 is the newest row
- up_val  in  1  column valid (`delay_val`)
- dn_data  out  IMG_WIDTH*HEIGHT_NB*WIDTH_NB  window; pixel (w,h) at bits [(w*HEIGHT_NB+h)*IMG_WIDTH +: IMG_WIDTH]; w=WIDTH_NB-1 is the newest column
- dn_val  out  1  window valid
- dn_eol  out  1  last window of a row (qualified by dn_val)
- dn_last  out  1  last window of a frame (qualified by dn_val)

## Operation
- The block has no backpressure. Every up_val beat is accepted.
- State IDLE: entered on reset.
  - up_val is ignored.
  - Outputs dn_val, dn_eol and dn_last are held at 0.
- IDLE -> RUN: taken on cfg_set when cfg_width >= WIDTH_NB and cfg_rows >= 1.
- cfg_set with illegal values: the block goes to, or stays in, IDLE.
- cfg_set in any state:
  - latches the config;
  - zeroes col and row;
  - forces dn_val/dn_eol/dn_last to 0 on the next cycle.
  - An up_val on the same cycle is dropped.
- RUN, on each up_val beat:
  - The window array shifts: column w takes column w+1, and column WIDTH_NB-1 takes up_data.
  - col increments. When col == cfg_width-1 it wraps to 0 and row increments.
  - When row == cfg_rows-1 and col wraps, row also wraps to 0. The next frame follows continuously; no reconfiguration is needed.
- Window validity is evaluated with the pre-increment col:
  - dn_val = (col >= WIDTH_NB-1);
  - dn_eol = (col == cfg_width-1);
  - dn_last = dn_eol && (row == cfg_rows-1).
- The window array is not cleared at a row wrap. Stale columns are never exposed, because dn_val stays low for the first WIDTH_NB-1 columns of each row.
- Windows per row = cfg_width - WIDTH_NB + 1. Windows per frame = that value times cfg_rows.
- Counters are compared at full CNT_WIDTH and are unsigned, with no overflow beyond cfg limits.

## Timing
- Latency is 1 cycle: an up_val beat at cycle N produces its dn_val/dn_data at N+1.
- dn_val is high for exactly one cycle per qualifying beat. It is low on cycles without up_val.
- Gaps in up_val are allowed. Counters and the array hold their values during gaps.
- dn_data is a registered output. It changes only on accepted beats and holds its value otherwise.
- Reset values:
  - dn_val, dn_eol, dn_last, col, row = 0;
  - dn_data = 0;
  - window array = 0;
  - cfg registers = 0;
  - state = IDLE.
- Reset mid-frame discards the partial frame. The block then requires a new cfg_set.
- cfg_set mid-row restarts counting at col=0 and row=0. Up to WIDTH_NB-1 stale columns remain in the array but are masked by dn_val.

## Test plan
- **Basic frame.** HEIGHT_NB=3, WIDTH_NB=3, cfg_width=8, cfg_rows=4. Stream 32 consecutive beats.
  - 24 dn_val pulses.
  - No dn_val on beats 0-1 of each row.
  - dn_eol on beats 7, 15, 23 and 31.
  - dn_last only on beat 31, one cycle later.
- **Window contents.** Drive column k with every pixel set to k.
  - The first valid window (after beat 2) has w=0,1,2 equal to 0,1,2 in all h.
  - The after-beat-7 window has 5,6,7.
- **Gapped input.** Same as the basic frame, with up_val deasserted randomly 50% of the time.
  - Identical dn_data/dn_eol/dn_last sequence.
  - Each output appears exactly 1 cycle after its beat.
- **Back-to-back frames.** Stream 64 beats.
  - dn_last on beats 31 and 63.
  - The first dn_val of frame 2 comes after beat 34.
- **Config handling.**
  - up_val before any cfg_set -> no dn_val.
  - cfg_set with cfg_width=2 (< WIDTH_NB) -> stays IDLE, no output.
  - cfg_set at col=5 mid-row -> the next two beats give no dn_val; the third beat gives dn_val.
- **Reset mid-frame.** Assert rst after beat 10.
  - All outputs 0 the following cycle.
  - Beats after reset are ignored until cfg_set.
